mdu_ctrl: RTL and testbench

Multi-cycle sequencer for the combinational multiply/divide unit in the execute stage. It accepts one M-extension op at a time over a valid/ready handshake and latches the operands. It drives the MAC's one-hot op lines for a fixed op-class latency, then captures and returns the result. It resolves RISC-V divide-by-zero and signed-overflow cases itself without occupying the MAC, and supports pipeline flush.

---
 rtl/mdu_ctrl_if.sv | 33 +++
 rtl/mdu_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_mdu_ctrl.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mdu_ctrl_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : mdu_ctrl_if                                              |
// | Description : Request/response bundle between the execute stage and    |
// |               the multiply/divide sequencer (mdu_ctrl).                |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
interface mdu_ctrl_if;
  // Request side: one M-extension op per valid/ready handshake
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic        in_word;
  logic [63:0] in_src1;
  logic [63:0] in_src2;
  // Response side: result held until the consumer takes it
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_result;

  // Execute stage issuing ops and consuming results
  modport master (
    output in_valid, in_op, in_word, in_src1, in_src2, out_ready,
    input  in_ready, out_valid, out_result
  );

  // Sequencer accepting ops and producing results
  modport slave (
    input  in_valid, in_op, in_word, in_src1, in_src2, out_ready,
    output in_ready, out_valid, out_result
  );
endinterface
`default_nettype wire

// File: rtl/mdu_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : mdu_ctrl                                                 |
// | Description : Multi-cycle sequencer for the combinational MUL/DIV MAC. |
// |               Accepts one op, drives the MAC one-hot op lines for a    |
// |               fixed per-class latency, captures and returns the        |
// |               result. Divide-by-zero and signed overflow are resolved  |
// |               locally without using the MAC. Supports flush.           |
// |               Optional feature macro: MDU_WORD_EN (RV64 *W variants).  |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module mdu_ctrl #(
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 8
) (
  input  logic        clock,
  input  logic        reset,
  mdu_ctrl_if.slave   bus,
  input  logic        flush,
  output logic        mac_mul,
  output logic        mac_mulh,
  output logic        mac_mulhu,
  output logic        mac_mulhsu,
  output logic        mac_div,
  output logic        mac_divu,
  output logic        mac_rem,
  output logic        mac_remu,
  output logic [63:0] mac_src1,
  output logic [63:0] mac_src2,
  input  logic [63:0] mac_result
);

  localparam int c_lat_max = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int c_cnt_w   = $clog2(c_lat_max + 1);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_busy = 2'd1;
  localparam logic [1:0] c_st_done = 2'd2;

  localparam logic [2:0] c_op_mul = 3'd0;
  localparam logic [2:0] c_op_div = 3'd4;
  localparam logic [2:0] c_op_rem = 3'd6;

  localparam logic [63:0] c_int_min = 64'h8000_0000_0000_0000;

  // Sign-extend a 32-bit value to 64 bits
  function automatic logic [63:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  // Registered state
  logic [1:0]         state_q,  state_d;
  logic [c_cnt_w-1:0] cnt_q,    cnt_d;
  logic [2:0]         op_q,     op_d;
  logic               word_q,   word_d;
  logic [63:0]        src1_q,   src1_d;
  logic [63:0]        src2_q,   src2_d;
  logic [63:0]        result_q, result_d;

  // Request-side decode
  logic        w_is_div;
  logic        w_signed_div;
  logic        w_word;
  logic [63:0] w_src1;
  logic [63:0] w_src2;
  logic        w_div_zero;
  logic        w_ovf;
  logic        w_special;
  logic [63:0] w_fixed_raw;
  logic [63:0] w_fixed;
  logic [63:0] w_mac_post;
  logic [7:0]  w_op_lines;

  // Operand preprocessing, special-case detection and fixed results
  always_comb begin
    w_is_div     = bus.in_op[2];
    w_signed_div = (bus.in_op == c_op_div) || (bus.in_op == c_op_rem);
    w_word       = 1'b0;
`ifdef MDU_WORD_EN
    // *W only exists for mul and the divide class; mulh* ignore in_word
    w_word = bus.in_word && (w_is_div || (bus.in_op == c_op_mul));
`else
    w_word = 1'b0;
`endif
    w_src1 = bus.in_src1;
    w_src2 = bus.in_src2;
    if (w_word) begin
      if (w_signed_div || (bus.in_op == c_op_mul)) begin
        w_src1 = sext32(bus.in_src1[31:0]);
        w_src2 = sext32(bus.in_src2[31:0]);
      end else begin
        w_src1 = {32'h0, bus.in_src1[31:0]};
        w_src2 = {32'h0, bus.in_src2[31:0]};
      end
    end
    // Extension preserves zero, so the 64-bit test covers the word case
    w_div_zero = w_is_div && (w_src2 == 64'h0);
    if (w_word) begin
      w_ovf = w_signed_div && (bus.in_src1[31:0] == 32'h8000_0000) &&
              (bus.in_src2[31:0] == 32'hFFFF_FFFF);
    end else begin
      w_ovf = w_signed_div && (bus.in_src1 == c_int_min) &&
              (bus.in_src2 == {64{1'b1}});
    end
    w_special = w_div_zero || w_ovf;
    // in_op[1] separates rem/remu from div/divu inside the divide class
    if (w_div_zero) begin
      w_fixed_raw = bus.in_op[1] ? w_src1 : {64{1'b1}};
    end else begin
      w_fixed_raw = bus.in_op[1] ? 64'h0 : w_src1;
    end
    w_fixed = w_word ? sext32(w_fixed_raw[31:0]) : w_fixed_raw;
  end

  // MAC result post-processing: *W results come back sign-extended from bit 31
  always_comb begin
    w_mac_post = word_q ? sext32(mac_result[31:0]) : mac_result;
  end

  // State and datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= c_st_idle;
      cnt_q    <= '0;
      op_q     <= 3'd0;
      word_q   <= 1'b0;
      src1_q   <= 64'h0;
      src2_q   <= 64'h0;
      result_q <= 64'h0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      word_q   <= word_d;
      src1_q   <= src1_d;
      src2_q   <= src2_d;
      result_q <= result_d;
    end
  end

  // Next-state logic; flush overrides every state and leaves result_q alone
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    word_d   = word_q;
    src1_d   = src1_q;
    src2_d   = src2_q;
    result_d = result_q;
    if (flush) begin
      state_d = c_st_idle;
      cnt_d   = '0;
    end else begin
      case (state_q)
        c_st_idle: begin
          if (bus.in_valid) begin
            op_d   = bus.in_op;
            word_d = w_word;
            src1_d = w_src1;
            src2_d = w_src2;
            if (w_special) begin
              state_d  = c_st_done;
              cnt_d    = '0;
              result_d = w_fixed;
            end else begin
              state_d = c_st_busy;
              cnt_d   = w_is_div ? c_cnt_w'(DIV_LAT) : c_cnt_w'(MUL_LAT);
            end
          end
        end
        c_st_busy: begin
          cnt_d = cnt_q - c_cnt_w'(1);
          if (cnt_q == c_cnt_w'(1)) begin
            result_d = w_mac_post;
            state_d  = c_st_done;
          end
        end
        c_st_done: begin
          if (bus.out_ready) begin
            state_d = c_st_idle;
          end
        end
        default: begin
          state_d = c_st_idle;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs: handshakes and one-hot MAC op lines decoded from the state
  always_comb begin
    bus.in_ready   = (state_q == c_st_idle) && !flush;
    bus.out_valid  = (state_q == c_st_done);
    bus.out_result = result_q;
    w_op_lines     = 8'h00;
    if (state_q == c_st_busy) begin
      w_op_lines = 8'h01 << op_q;
    end
    mac_mul    = w_op_lines[0];
    mac_mulh   = w_op_lines[1];
    mac_mulhu  = w_op_lines[2];
    mac_mulhsu = w_op_lines[3];
    mac_div    = w_op_lines[4];
    mac_divu   = w_op_lines[5];
    mac_rem    = w_op_lines[6];
    mac_remu   = w_op_lines[7];
    mac_src1   = src1_q;
    mac_src2   = src2_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_mdu_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_mdu_ctrl                                              |
// | Description : Scoreboard bench for mdu_ctrl with a behavioural MAC.    |
// |               Word-variant vectors are used when MDU_WORD_EN is set.   |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module tb_mdu_ctrl;
  localparam int MUL_LAT = 3;
  localparam int DIV_LAT = 8;
  localparam logic [2:0] OP_MUL = 3'd0, OP_MULH = 3'd1, OP_MULHU = 3'd2, OP_MULHSU = 3'd3;
  localparam logic [2:0] OP_DIV = 3'd4, OP_DIVU = 3'd5, OP_REM = 3'd6, OP_REMU = 3'd7;
  localparam logic [63:0] ONES = {64{1'b1}};
  localparam logic [63:0] MIN  = 64'h8000_0000_0000_0000;

  logic clock = 1'b0;
  logic reset;
  logic flush;
  always #5 clock = ~clock;

  mdu_ctrl_if bus();
  logic mac_mul, mac_mulh, mac_mulhu, mac_mulhsu, mac_div, mac_divu, mac_rem, mac_remu;
  logic [63:0] mac_src1, mac_src2, mac_result;
  wire  [7:0]  lines = {mac_remu, mac_rem, mac_divu, mac_div, mac_mulhsu, mac_mulhu, mac_mulh, mac_mul};

  mdu_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clock(clock), .reset(reset), .bus(bus), .flush(flush),
    .mac_mul(mac_mul), .mac_mulh(mac_mulh), .mac_mulhu(mac_mulhu), .mac_mulhsu(mac_mulhsu),
    .mac_div(mac_div), .mac_divu(mac_divu), .mac_rem(mac_rem), .mac_remu(mac_remu),
    .mac_src1(mac_src1), .mac_src2(mac_src2), .mac_result(mac_result)
  );

  // Behavioural combinational MAC
  logic [127:0] prod;
  always_comb begin
    prod       = 128'h0;
    mac_result = 64'h0;
    if (mac_mul) begin
      mac_result = mac_src1 * mac_src2;
    end else if (mac_mulh) begin
      prod = {{64{mac_src1[63]}}, mac_src1} * {{64{mac_src2[63]}}, mac_src2};
      mac_result = prod[127:64];
    end else if (mac_mulhu) begin
      prod = {64'h0, mac_src1} * {64'h0, mac_src2};
      mac_result = prod[127:64];
    end else if (mac_mulhsu) begin
      prod = {{64{mac_src1[63]}}, mac_src1} * {64'h0, mac_src2};
      mac_result = prod[127:64];
    end else if (mac_div) begin
      if (mac_src2 == 64'h0) mac_result = ONES;
      else if (mac_src1 == MIN && mac_src2 == ONES) mac_result = MIN;
      else mac_result = 64'($signed(mac_src1) / $signed(mac_src2));
    end else if (mac_divu) begin
      mac_result = (mac_src2 == 64'h0) ? ONES : mac_src1 / mac_src2;
    end else if (mac_rem) begin
      if (mac_src2 == 64'h0) mac_result = mac_src1;
      else if (mac_src1 == MIN && mac_src2 == ONES) mac_result = 64'h0;
      else mac_result = 64'($signed(mac_src1) % $signed(mac_src2));
    end else if (mac_remu) begin
      mac_result = (mac_src2 == 64'h0) ? mac_src1 : mac_src1 % mac_src2;
    end
  end

  typedef struct {
    logic [63:0] res;
    int          lat;
    int          mac;
    logic [2:0]  op;
    logic [63:0] s1;
    logic [63:0] s2;
    int          id;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   next_id = 0;
  int   cyc = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string what, input int id, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (vec %0d): got %h want %h", what, id, act, exp);
    end
  endtask

  // Monitor: observes accepts, MAC activity and results; pops the scoreboard
  int acc_cyc = 0;
  int mac_cnt = 0;
  bit seen_valid = 1'b0;
  always @(negedge clock) begin
    if (!reset) begin
      if (bus.in_valid && bus.in_ready) begin
        acc_cyc    = cyc;
        mac_cnt    = 0;
        seen_valid = 1'b0;
        chk("accept with op pending", next_id, 64'(sb.size()), 64'd1);
      end
      if (lines != 8'h00) begin
        mac_cnt++;
        chk("in_ready while busy", -1, {63'h0, bus.in_ready}, 64'h0);
        if (sb.size() == 0) begin
          chk("mac line with no request", -1, {56'h0, lines}, 64'h0);
        end else begin
          chk("mac op line", sb[0].id, {56'h0, lines}, 64'(8'h01 << sb[0].op));
          chk("mac_src1", sb[0].id, mac_src1, sb[0].s1);
          chk("mac_src2", sb[0].id, mac_src2, sb[0].s2);
        end
      end
      if (bus.out_valid) begin
        chk("in_ready while done", -1, {63'h0, bus.in_ready}, 64'h0);
        if (sb.size() == 0) begin
          chk("unexpected out_valid", -1, 64'h1, 64'h0);
        end else begin
          if (!seen_valid) begin
            chk("latency", sb[0].id, 64'(cyc - acc_cyc), 64'(sb[0].lat));
            seen_valid = 1'b1;
          end
          chk("out_result", sb[0].id, bus.out_result, sb[0].res);
          if (bus.out_ready) begin
            chk("mac cycles", sb[0].id, 64'(mac_cnt), 64'(sb[0].mac));
            void'(sb.pop_front());
          end
        end
      end
      if (flush && sb.size() != 0) void'(sb.pop_front());
    end
  end

  task automatic send(input logic [2:0] op, input logic w, input logic [63:0] a, input logic [63:0] b,
                      input logic [63:0] r, input int lat, input int mac,
                      input logic [63:0] s1, input logic [63:0] s2);
    exp_t e;
    bit   ok;
    e.res = r; e.lat = lat; e.mac = mac; e.op = op; e.s1 = s1; e.s2 = s2; e.id = next_id;
    next_id++;
    sb.push_back(e);
    bus.in_valid = 1'b1; bus.in_op = op; bus.in_word = w; bus.in_src1 = a; bus.in_src2 = b;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("accept timeout", e.id, 64'h0, 64'h1);
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (sb.size() == 0 && !bus.out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("idle timeout", -1, 64'h0, 64'h1);
    @(posedge clock); #1;
  endtask

  localparam int ML = MUL_LAT + 1;
  localparam int DL = DIV_LAT + 1;

  initial begin
    reset = 1'b1; flush = 1'b0;
    bus.in_valid = 1'b0; bus.in_op = 3'd0; bus.in_word = 1'b0;
    bus.in_src1 = 64'h0; bus.in_src2 = 64'h0; bus.out_ready = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("reset in_ready", -1, {63'h0, bus.in_ready}, 64'h1);
    chk("reset out_valid", -1, {63'h0, bus.out_valid}, 64'h0);
    chk("reset out_result", -1, bus.out_result, 64'h0);
    chk("reset op lines", -1, {56'h0, lines}, 64'h0);
    chk("reset mac_src1", -1, mac_src1, 64'h0);
    chk("reset mac_src2", -1, mac_src2, 64'h0);
    @(posedge clock); #1;
    reset = 1'b0;

    // Basic multiply
    send(OP_MUL, 0, 64'd7, -64'sd3, 64'hFFFF_FFFF_FFFF_FFEB, ML, MUL_LAT, 64'd7, -64'sd3);
    wait_idle();
    // Back-to-back unsigned divide / remainder
    send(OP_DIVU, 0, 64'd100, 64'd7, 64'd14, DL, DIV_LAT, 64'd100, 64'd7);
    send(OP_REMU, 0, 64'd100, 64'd7, 64'd2,  DL, DIV_LAT, 64'd100, 64'd7);
    wait_idle();
    // Special cases resolved without the MAC
    send(OP_DIV,  0, 64'd5, 64'd0, ONES,  1, 0, 64'd5, 64'd0);
    send(OP_REM,  0, 64'd5, 64'd0, 64'd5, 1, 0, 64'd5, 64'd0);
    send(OP_DIV,  0, MIN, ONES, MIN,   1, 0, MIN, ONES);
    send(OP_REM,  0, MIN, ONES, 64'h0, 1, 0, MIN, ONES);
    send(OP_DIVU, 0, 64'd5, 64'd0, ONES,  1, 0, 64'd5, 64'd0);
    send(OP_REMU, 0, 64'd5, 64'd0, 64'd5, 1, 0, 64'd5, 64'd0);
    wait_idle();
    // Signed divide/remainder and high multiplies through the MAC
    send(OP_DIV,    0, -64'sd100, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, DL, DIV_LAT, -64'sd100, 64'd7);
    send(OP_REM,    0, -64'sd100, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, DL, DIV_LAT, -64'sd100, 64'd7);
    send(OP_MULH,   0, 64'h4000_0000_0000_0000, 64'd4, 64'd1, ML, MUL_LAT, 64'h4000_0000_0000_0000, 64'd4);
    send(OP_MULHSU, 0, ONES, 64'd2, ONES, ML, MUL_LAT, ONES, 64'd2);
    wait_idle();

    // Result held while the consumer stalls
    bus.out_ready = 1'b0;
    send(OP_MULHU, 0, ONES, 64'd2, 64'd1, ML, MUL_LAT, ONES, 64'd2);
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (bus.out_valid) break;
    end
    repeat (4) @(negedge clock);
    @(posedge clock); #1;
    bus.out_ready = 1'b1;
    @(negedge clock);
    @(negedge clock);
    chk("out_valid after handshake", -1, {63'h0, bus.out_valid}, 64'h0);
    wait_idle();

    // Flush on the second busy cycle with a competing request
    send(OP_DIV, 0, 64'd100, 64'd7, 64'd14, DL, DIV_LAT, 64'd100, 64'd7);
    @(posedge clock); #1;
    flush = 1'b1;
    bus.in_valid = 1'b1; bus.in_op = OP_MUL; bus.in_word = 1'b0;
    bus.in_src1 = 64'd1; bus.in_src2 = 64'd1;
    @(negedge clock);
    chk("in_ready on flush cycle", -1, {63'h0, bus.in_ready}, 64'h0);
    @(posedge clock); #1;
    flush = 1'b0; bus.in_valid = 1'b0;
    @(negedge clock);
    chk("in_ready after flush", -1, {63'h0, bus.in_ready}, 64'h1);
    chk("op lines after flush", -1, {56'h0, lines}, 64'h0);
    chk("out_valid after flush", -1, {63'h0, bus.out_valid}, 64'h0);
    chk("out_result kept over flush", -1, bus.out_result, 64'd1);
    repeat (12) @(negedge clock);
    @(posedge clock); #1;
    send(OP_MUL, 0, 64'd3, 64'd5, 64'd15, ML, MUL_LAT, 64'd3, 64'd5);
    wait_idle();

`ifdef MDU_WORD_EN
    send(OP_DIV,  1, 64'h0000_0001_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1, 0,
         64'hFFFF_FFFF_8000_0000, ONES);
    send(OP_MUL,  1, 64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, ML, MUL_LAT,
         64'h0000_0000_7FFF_FFFF, 64'd2);
    send(OP_DIVU, 1, 64'h0000_0001_FFFF_FFFF, 64'h0000_000F_0000_0002, 64'h0000_0000_7FFF_FFFF, DL, DIV_LAT,
         64'h0000_0000_FFFF_FFFF, 64'd2);
    send(OP_REM,  1, 64'h0000_0001_0000_0005, 64'h0000_0001_0000_0000, 64'd5, 1, 0, 64'd5, 64'd0);
    send(OP_REM,  1, 64'hAAAA_AAAA_FFFF_FFF9, 64'd2, ONES, DL, DIV_LAT, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2);
    send(OP_MULHU, 1, ONES, 64'd2, 64'd1, ML, MUL_LAT, ONES, 64'd2);
`else
    send(OP_MUL, 1, 64'h0000_0001_0000_0000, 64'd2, 64'h0000_0002_0000_0000, ML, MUL_LAT,
         64'h0000_0001_0000_0000, 64'd2);
    send(OP_DIV, 1, 64'h0000_0001_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'd1, DL, DIV_LAT,
         64'h0000_0001_8000_0000, 64'h0000_0000_FFFF_FFFF);
`endif
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
